// File: rtl/mips_mc_hs.sv
// Multicycle MIPS-subset core with a req/ready memory handshake, precise traps
// (illegal opcode/funct, misaligned lw/sw/jr) to EXC_VECTOR, and a retired-instruction counter.
module mips_mc_hs #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wr_data,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rd_data,
  output logic [31:0]      PC,
  output logic [31:0]      epc,
  output logic             exc,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      alu_out_q, alu_out_d;
  logic [31:0]      mdr_q, mdr_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm, mem_ea, alu_res;
  logic        legal, retire;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign target   = ir_q[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign mem_ea   = a_q + sext_imm;

  always_comb begin
    legal = 1'b0;
    if (op == OP_R) begin
      case (funct)
        F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
        default:                                              legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
        default:                                             legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    alu_res = a_q + sext_imm;
    if (op == OP_R) begin
      case (funct)
        F_ADD:   alu_res = a_q + b_q;
        F_SUB:   alu_res = a_q - b_q;
        F_AND:   alu_res = a_q & b_q;
        F_OR:    alu_res = a_q | b_q;
        F_SLT:   alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
        F_SLL:   alu_res = b_q << shamt;
        F_SRL:   alu_res = b_q >> shamt;
        default: alu_res = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    epc_d     = epc_q;
    regs_d    = regs_q;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rd_data;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d       = regs_q[rs];
        b_d       = regs_q[rt];
        alu_out_d = pc_q + {sext_imm[29:0], 2'b00};
        state_d   = legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (op)
          OP_R: begin
            if (funct == F_JR) begin
              if (a_q[1:0] != 2'b00) begin
                state_d = TRAP;
              end else begin
                pc_d    = a_q;
                retire  = 1'b1;
                state_d = FETCH;
              end
            end else begin
              alu_out_d = alu_res;
              state_d   = WB;
            end
          end
          OP_ADDI: begin
            alu_out_d = alu_res;
            state_d   = WB;
          end
          OP_LW, OP_SW: begin
            alu_out_d = mem_ea;
            state_d   = (mem_ea[1:0] != 2'b00) ? TRAP : MEM;
          end
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (op == OP_BEQ)) pc_d = alu_out_q;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_J, OP_JAL: begin
            // PC already points at instr+4, which is also the jal link value
            pc_d = {pc_q[31:28], target, 2'b00};
            if (op == OP_JAL) regs_d[31] = pc_q;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = mem_rd_data;
            state_d = WB;
          end
        end
      end
      WB: begin
        if (op == OP_R) begin
          if (rd != 5'd0) regs_d[rd] = alu_out_q;
        end else if (rt != 5'd0) begin
          regs_d[rt] = (op == OP_LW) ? mdr_q : alu_out_q;
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        epc_d   = pc_q - 32'd4;
        pc_d    = EXC_VECTOR;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      epc_q     <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      epc_q     <= epc_d;
      retired_q <= retired_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Request is gated by rst so an in-flight transfer drops in the reset cycle itself
  assign mem_req       = !rst && (state_q == FETCH || state_q == MEM);
  assign mem_we        = !rst && (state_q == MEM) && (op == OP_SW);
  assign mem_addr      = (state_q == FETCH) ? pc_q : alu_out_q;
  assign mem_wr_data   = b_q;
  assign PC            = pc_q;
  assign epc           = epc_q;
  assign exc           = (state_q == TRAP);
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_mc_hs.sv
// Scoreboard bench for mips_mc_hs: a wait-state memory model records every store,
// and each scenario compares them against the stores it expects the program to make.
`timescale 1ns/1ps
module tb_mips_mc_hs;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, exc;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data, PC, epc;
  logic [31:0] instr_retired;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          fetch_waits = 0;
  int          data_waits = 0;
  bit          rand_waits = 1'b0;
  int          data_req_cnt = 0;

  mips_mc_hs #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .PC(PC), .epc(epc), .exc(exc), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Memory responder: decides ready on the falling edge, so the core sees it at the next rise
  initial begin : responder
    bit  busy;
    int  cnt;
    int  cur;
    wr_t w;
    busy = 1'b0; cnt = 0; cur = 0;
    mem_ready = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          cur  = rand_waits ? int'($urandom_range(0, 3)) :
                 ((mem_addr < RESET_PC) ? data_waits : fetch_waits);
          if (mem_addr < RESET_PC) data_req_cnt++;
        end
        if (cnt >= cur) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wr_data;
            w.addr = mem_addr;
            w.data = mem_wr_data;
            obs_q.push_back(w);
          end else begin
            mem_rd_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          end
          $display("[%0t] mem %s addr=%08h data=%08h", $time, mem_we ? "WR" : "RD",
                   mem_addr, mem_we ? mem_wr_data : mem_rd_data);
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_j(int op, logic [31:0] addr);
    return {6'(op), addr[27:2]};
  endfunction

  task automatic put(int idx, logic [31:0] instr);
    mem[RESET_PC + 32'(idx * 4)] = instr;
  endtask

  task automatic expect_wr(logic [31:0] addr, logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    mem.delete();
    exp_q.delete();
    obs_q.delete();
    fetch_waits = 0; data_waits = 0; rand_waits = 1'b0; data_req_cnt = 0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(int n, int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    ok = (obs_q.size() >= n);
  endtask

  task automatic load_alu_prog();
    logic [31:0] vals [8];
    vals = '{32'hFFFF_FFFE, 32'h0000_000C, 32'h0000_0001, 32'hFFFF_FFFD,
             32'h0000_0001, 32'h0000_0000, 32'h0000_0050, 32'h0000_000F};
    put(0,  enc_i(8, 0, 1, 5));
    put(1,  enc_i(8, 0, 2, -7));
    put(2,  enc_r(1, 2, 3, 0, 'h20));
    put(3,  enc_r(1, 2, 4, 0, 'h22));
    put(4,  enc_r(1, 2, 5, 0, 'h24));
    put(5,  enc_r(1, 2, 6, 0, 'h25));
    put(6,  enc_r(2, 1, 7, 0, 'h2A));
    put(7,  enc_r(1, 2, 8, 0, 'h2A));
    put(8,  enc_r(0, 1, 9, 4, 'h00));
    put(9,  enc_r(0, 2, 10, 28, 'h02));
    put(10, enc_r(1, 1, 0, 0, 'h20));
    for (int k = 0; k < 8; k++) begin
      put(11 + k, enc_i('h2B, 0, 3 + k, 'h40 + 4 * k));
      expect_wr(32'h40 + 32'(4 * k), vals[k]);
    end
    put(19, enc_i('h2B, 0, 0, 'h60));
    expect_wr(32'h60, 32'h0);
  endtask

  task automatic test_reset();
    hold_reset();
    put(0, enc_i(8, 0, 1, 5));
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", mem_we); end
    n_cmp++; if (PC !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, RESET_PC); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_cmp++; if (exc !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b want 0", exc); end
    n_cmp++; if (instr_retired !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", instr_retired); end
    release_rst();
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC || mem_we !== 1'b0) begin
      n_err++; $display("FAIL first_fetch: got req=%b we=%b addr=%h want 1 0 %h", mem_req, mem_we, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_addi_sw_lw();
    bit  ok;
    wr_t e, o;
    hold_reset();
    put(0, enc_i(8, 0, 1, 5));
    put(1, enc_i(8, 1, 2, -7));
    put(2, enc_i('h2B, 0, 2, 4));
    put(3, enc_i('h23, 0, 3, 4));
    put(4, enc_i('h2B, 0, 3, 8));
    expect_wr(32'h4, 32'hFFFF_FFFE);
    expect_wr(32'h8, 32'hFFFF_FFFE);
    release_rst();
    step(8);
    n_cmp++; if (PC !== RESET_PC + 32'h8) begin n_err++; $display("FAIL addi_pc: got %h want %h", PC, RESET_PC + 32'h8); end
    n_cmp++; if (instr_retired !== 32'd2) begin n_err++; $display("FAIL addi_cnt: got %0d want 2", instr_retired); end
    step(3);
    n_cmp++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h4 || mem_wr_data !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL sw_req: got req=%b we=%b addr=%h data=%h want 1 1 00000004 fffffffe", mem_req, mem_we, mem_addr, mem_wr_data);
    end
    step(6);
    n_cmp++; if (instr_retired !== 32'd4) begin n_err++; $display("FAIL lw_cnt: got %0d want 4", instr_retired); end
    wait_writes(2, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sw_lw_timeout: got %0d writes want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL sw_lw_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  task automatic test_alu();
    bit  ok;
    wr_t e, o;
    hold_reset();
    load_alu_prog();
    release_rst();
    wait_writes(9, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL alu_timeout: got %0d writes want 9", obs_q.size()); end
    n_cmp++; if (instr_retired !== 32'd20) begin n_err++; $display("FAIL alu_cnt: got %0d want 20", instr_retired); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL alu_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  task automatic test_fetch_stall();
    bit  ok;
    wr_t e, o;
    hold_reset();
    fetch_waits = 3;
    put(0, enc_i(8, 0, 1, 5));
    put(1, enc_i('h2B, 0, 1, 0));
    expect_wr(32'h0, 32'h5);
    release_rst();
    for (int k = 1; k <= 3; k++) begin
      step(1);
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC || PC !== RESET_PC) begin
        n_err++; $display("FAIL stall_hold%0d: got req=%b addr=%h pc=%h want 1 %h %h", k, mem_req, mem_addr, PC, RESET_PC, RESET_PC);
      end
    end
    step(1);
    n_cmp++; if (PC !== RESET_PC + 32'h4) begin n_err++; $display("FAIL stall_pc: got %h want %h", PC, RESET_PC + 32'h4); end
    step(2);
    n_cmp++; if (instr_retired !== 32'd0) begin n_err++; $display("FAIL stall_cnt6: got %0d want 0", instr_retired); end
    step(1);
    n_cmp++; if (instr_retired !== 32'd1) begin n_err++; $display("FAIL stall_cnt7: got %0d want 1", instr_retired); end
    wait_writes(1, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: got %0d writes want 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL stall_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  task automatic test_branch();
    bit  ok;
    wr_t e, o;
    hold_reset();
    put(0,  enc_i(8, 0, 1, 1));
    put(1,  enc_i(5, 0, 0, 5));
    put(2,  enc_j(2, RESET_PC + 32'h10));
    put(3,  enc_j(2, RESET_PC + 32'h18));
    put(4,  enc_i(4, 1, 1, -2));
    put(5,  enc_i('h2B, 0, 0, 'h20));
    put(6,  enc_j(3, RESET_PC + 32'h24));
    put(7,  enc_i('h2B, 0, 1, 'h28));
    put(9,  enc_i('h2B, 0, 31, 'h30));
    put(10, enc_i(8, 31, 5, 'h18));
    put(11, enc_r(5, 0, 0, 0, 'h08));
    put(12, enc_i('h2B, 0, 0, 'h3C));
    put(13, enc_i('h2B, 0, 1, 'h38));
    expect_wr(32'h30, RESET_PC + 32'h1C);
    expect_wr(32'h38, 32'h1);
    release_rst();
    step(7);
    n_cmp++; if (PC !== RESET_PC + 32'h8) begin n_err++; $display("FAIL bne_nt_pc: got %h want %h", PC, RESET_PC + 32'h8); end
    step(6);
    n_cmp++; if (PC !== RESET_PC + 32'hC) begin n_err++; $display("FAIL beq_pc: got %h want %h", PC, RESET_PC + 32'hC); end
    step(6);
    n_cmp++; if (PC !== RESET_PC + 32'h24) begin n_err++; $display("FAIL jal_pc: got %h want %h", PC, RESET_PC + 32'h24); end
    step(11);
    n_cmp++; if (PC !== RESET_PC + 32'h34) begin n_err++; $display("FAIL jr_pc: got %h want %h", PC, RESET_PC + 32'h34); end
    n_cmp++; if (instr_retired !== 32'd9) begin n_err++; $display("FAIL branch_cnt: got %0d want 9", instr_retired); end
    wait_writes(2, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL branch_timeout: got %0d writes want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL branch_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  task automatic test_trap();
    hold_reset();
    put(0, enc_i(8, 0, 1, 2));
    put(8, 32'hFC00_0000);
    mem[EXC_VECTOR] = enc_i('h23, 0, 3, 2);
    release_rst();
    step(33);
    n_cmp++; if (exc !== 1'b0 || instr_retired !== 32'd8) begin
      n_err++; $display("FAIL pre_trap: got exc=%b cnt=%0d want 0 8", exc, instr_retired);
    end
    step(1);
    n_cmp++; if (exc !== 1'b1) begin n_err++; $display("FAIL ill_exc: got %b want 1", exc); end
    step(1);
    n_cmp++; if (exc !== 1'b0) begin n_err++; $display("FAIL ill_exc_pulse: got %b want 0", exc); end
    n_cmp++; if (epc !== RESET_PC + 32'h20) begin n_err++; $display("FAIL ill_epc: got %h want %h", epc, RESET_PC + 32'h20); end
    n_cmp++; if (PC !== EXC_VECTOR) begin n_err++; $display("FAIL ill_pc: got %h want %h", PC, EXC_VECTOR); end
    n_cmp++; if (instr_retired !== 32'd8) begin n_err++; $display("FAIL ill_cnt: got %0d want 8", instr_retired); end
    step(2);
    n_cmp++; if (exc !== 1'b0) begin n_err++; $display("FAIL mis_exec_exc: got %b want 0", exc); end
    step(1);
    n_cmp++; if (exc !== 1'b1) begin n_err++; $display("FAIL mis_exc: got %b want 1", exc); end
    step(1);
    n_cmp++; if (epc !== EXC_VECTOR || PC !== EXC_VECTOR) begin
      n_err++; $display("FAIL mis_epc_pc: got epc=%h pc=%h want %h %h", epc, PC, EXC_VECTOR, EXC_VECTOR);
    end
    n_cmp++; if (data_req_cnt !== 0 || instr_retired !== 32'd8) begin
      n_err++; $display("FAIL mis_noreq: got dreq=%0d cnt=%0d want 0 8", data_req_cnt, instr_retired);
    end
  endtask

  task automatic test_reset_mid_mem();
    bit  ok;
    wr_t e, o;
    hold_reset();
    put(0, enc_i('h2B, 0, 1, 4));
    put(1, enc_i(8, 0, 1, 7));
    put(2, enc_i('h2B, 0, 1, 0));
    expect_wr(32'h4, 32'h0);
    release_rst();
    step(8);
    n_cmp++; if (instr_retired !== 32'd2) begin n_err++; $display("FAIL mid_cnt: got %0d want 2", instr_retired); end
    data_waits = 20;
    step(5);
    n_cmp++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h0 || mem_wr_data !== 32'h7) begin
      n_err++; $display("FAIL mid_req: got req=%b we=%b addr=%h data=%h want 1 1 00000000 00000007", mem_req, mem_we, mem_addr, mem_wr_data);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_req, mem_we} !== 2'b00) begin n_err++; $display("FAIL mid_drop: got req=%b we=%b want 0 0", mem_req, mem_we); end
    n_cmp++; if (PC !== RESET_PC || instr_retired !== 32'd0) begin
      n_err++; $display("FAIL mid_state: got pc=%h cnt=%0d want %h 0", PC, instr_retired, RESET_PC);
    end
    data_waits = 0;
    expect_wr(32'h4, 32'h0);
    expect_wr(32'h0, 32'h7);
    release_rst();
    wait_writes(3, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_timeout: got %0d writes want 3", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL mid_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    wr_t e, o;
    hold_reset();
    load_alu_prog();
    rand_waits = 1'b1;
    release_rst();
    wait_writes(9, 2000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_timeout: got %0d writes want 9", obs_q.size()); end
    n_cmp++; if (instr_retired !== 32'd20) begin n_err++; $display("FAIL rand_cnt: got %0d want 20", instr_retired); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL rand_wr: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr); end
    end
  endtask

  initial begin
    test_reset();
    test_addi_sw_lw();
    test_alu();
    test_fetch_stall();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
